// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state
// encoding, HALT opcode, PC reset/step constants and PC helpers.
package fetch_ctrl_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_OUT    = 2'd2,
    ST_HALTED = 2'd3
  } fetchState_e;

  localparam logic [4:0]      OPC_HALT = 5'b00000;
  localparam logic [PC_W-1:0] PC_RESET = 16'h0000;
  localparam logic [PC_W-1:0] PC_STEP  = 16'h0002;

  // Sequential PC advance; the carry out of bit 15 is discarded so the
  // address space wraps (0xFFFE -> 0x0000).
  function automatic logic [PC_W-1:0] pcAdvance(input logic [PC_W-1:0] cur);
    return cur + PC_STEP;
  endfunction

  // HALT is recognised purely from the five opcode bits.
  function automatic logic isHalt(input logic [INSTR_W-1:0] word);
    return word[15:11] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Architectural program counter: synchronous reset, redirect load and
// increment-by-2. A load always wins over an increment.
module pc_reg
  import fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] loadVal,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // PC update: reset, then redirect, then sequential advance
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_RESET;
    end else if (load) begin
      pc <= loadVal;
    end else if (inc) begin
      pc <= pcAdvance(pc);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller. Owns the PC, issues one read at a time to a
// multi-cycle instruction memory, presents each fetched instruction to decode
// with a valid/stall handshake, squashes in-flight fetches on redirect and
// parks after presenting HALT.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap odd fetch addresses
// (no request is issued, misalign sets sticky and the fetcher parks).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    next_pc,
  input  logic               pc_load,
  input  logic               stall,
  output logic               mem_rd,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_done,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus2,
  output logic               halted,
  output logic               misalign
);

  fetchState_e        state;
  fetchState_e        stateNext;
  logic               squash;
  logic               squashNext;
  logic [PC_W-1:0]    pc;
  logic               pcLoad;
  logic               pcInc;
  logic               capture;
  logic               alignFault;
  logic               setMisalign;

  logic [INSTR_W-1:0] instrQ;
  logic [PC_W-1:0]    pcOutQ;
  logic [PC_W-1:0]    pcPlus2Q;
  logic               instrValidQ;
  logic               haltedQ;
  logic               misalignQ;

  pc_reg uPcReg (
    .clk     (clk),
    .rst     (rst),
    .load    (pcLoad),
    .loadVal (next_pc),
    .inc     (pcInc),
    .pc      (pc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign alignFault = pc[0];
`else
  assign alignFault = 1'b0;
`endif

  // Read request is a pure decode of state and PC, held low while in reset
  // so nothing is issued during the reset cycle itself.
  assign mem_rd   = !rst && (state == ST_REQ) && !alignFault;
  assign mem_addr = pc;

  assign instr       = instrQ;
  assign instr_valid = instrValidQ;
  assign pc_out      = pcOutQ;
  assign pc_plus2    = pcPlus2Q;
  assign halted      = haltedQ;
  assign misalign    = misalignQ;

  // State and squash-flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_REQ;
      squash <= 1'b0;
    end else begin
      state  <= stateNext;
      squash <= squashNext;
    end
  end

  // Next-state and PC control; redirect outranks stall everywhere but HALTED
  always_comb begin
    stateNext   = state;
    squashNext  = squash;
    pcLoad      = 1'b0;
    pcInc       = 1'b0;
    capture     = 1'b0;
    setMisalign = 1'b0;
    case (state)
      ST_REQ: begin
        if (alignFault) begin
          setMisalign = 1'b1;
          stateNext   = ST_HALTED;
        end else begin
          // The request at the old PC still goes out; a redirect just marks
          // its response as stale.
          squashNext = pc_load;
          pcLoad     = pc_load;
          stateNext  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pc_load) begin
          pcLoad     = 1'b1;
          squashNext = 1'b1;
        end
        if (mem_done) begin
          squashNext = 1'b0;
          if (squash || pc_load) begin
            stateNext = ST_REQ;
          end else begin
            capture   = 1'b1;
            pcInc     = 1'b1;
            stateNext = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (pc_load) begin
          pcLoad    = 1'b1;
          stateNext = ST_REQ;
        end else if (!stall) begin
          stateNext = isHalt(instrQ) ? ST_HALTED : ST_REQ;
        end
      end
      ST_HALTED: begin
        stateNext = ST_HALTED;
      end
      default: begin
        stateNext = ST_REQ;
      end
    endcase
  end

  // Registered outputs: valid/halted follow the upcoming state, the
  // instruction/PC triple loads only on an accepted response.
  always_ff @(posedge clk) begin
    if (rst) begin
      instrQ      <= '0;
      pcOutQ      <= PC_RESET;
      pcPlus2Q    <= pcAdvance(PC_RESET);
      instrValidQ <= 1'b0;
      haltedQ     <= 1'b0;
      misalignQ   <= 1'b0;
    end else begin
      instrValidQ <= (stateNext == ST_OUT);
      haltedQ     <= (stateNext == ST_HALTED);
      misalignQ   <= misalignQ | setMisalign;
      if (capture) begin
        instrQ   <= mem_rdata;
        pcOutQ   <= pc;
        pcPlus2Q <= pcAdvance(pc);
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a randomized instruction memory with
// variable latency plus a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] next_pc;
  logic        pc_load;
  logic        stall;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        halted;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .pc_load     (pc_load),
    .stall       (stall),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .pc_plus2    (pc_plus2),
    .halted      (halted),
    .misalign    (misalign)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory contents
  bit          haltEn   = 1'b0;
  logic [15:0] haltAddr = 16'h0006;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (haltEn && a == haltAddr) return 16'h0000;
    if (a == 16'h0002) return 16'h1234;
    return ((a * 16'h9E37) ^ 16'h1234) | 16'h0800;
  endfunction

  // Memory responder
  int          respCnt  = 0;
  logic [15:0] respAddr = '0;
  int          latLo    = 1;
  int          latHi    = 1;

  // Reference model: the fetch stream as a sequence of transactions
  logic [15:0] mPc        = 16'h0000;  // next address to fetch
  bit          mOut       = 1'b0;      // a read is in flight
  bit          mLive      = 1'b0;      // in-flight read still wanted
  logic [15:0] mReqAddr   = '0;
  bit          mPres      = 1'b0;      // an instruction is offered to decode
  logic [15:0] mLastInstr = 16'h0000;  // most recently delivered instruction
  logic [15:0] mLastPc    = 16'h0000;
  bit          mHalt      = 1'b0;
  bit          mMis       = 1'b0;

  task automatic stepCycle(input bit rI, input bit ldI, input logic [15:0] npI,
                           input bit stI, input bit strayDone);
    bit doneI;
    bit expRd;
    bit alignTrap;
    doneI = 1'b0;
    if (respCnt > 0) begin
      respCnt--;
      doneI = (respCnt == 0);
    end
    doneI     = doneI | strayDone;
    rst       = rI;
    pc_load   = ldI;
    next_pc   = npI;
    stall     = stI;
    mem_done  = doneI;
    mem_rdata = doneI ? memWord(respAddr) : 16'($urandom);
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    alignTrap = mPc[0];
`else
    alignTrap = 1'b0;
`endif
    expRd = !rI && !mHalt && !mOut && !mPres && !alignTrap;
    checkEq("memRd", 16'(mem_rd), 16'(expRd));
    if (expRd) checkEq("memAddr", mem_addr, mPc);
    checkEq("instrValid", 16'(instr_valid), 16'(mPres));
    checkEq("halted", 16'(halted), 16'(mHalt));
    checkEq("misalign", 16'(misalign), 16'(mMis));
    checkEq("instr", instr, mLastInstr);
    checkEq("pcOut", pc_out, mLastPc);
    checkEq("pcPlus2", pc_plus2, mLastPc + 16'd2);
    // memory sees the request
    if (rI) respCnt = 0;
    else if (mem_rd) begin
      respCnt  = $urandom_range(latHi, latLo);
      respAddr = mem_addr;
    end
    // advance the model by this cycle's inputs
    if (rI) begin
      mPc = 16'h0000; mOut = 0; mLive = 0; mPres = 0; mHalt = 0; mMis = 0;
      mLastInstr = 16'h0000; mLastPc = 16'h0000;
    end else if (mHalt) begin
      // parked: redirects and stalls have no effect
    end else if (!mOut && !mPres && alignTrap) begin
      mHalt = 1'b1;
      mMis  = 1'b1;
    end else if (expRd) begin
      mOut     = 1'b1;
      mLive    = !ldI;
      mReqAddr = mPc;
      if (ldI) mPc = npI;
    end else if (mOut) begin
      if (doneI) begin
        mOut = 1'b0;
        if (mLive && !ldI) begin
          mPres      = 1'b1;
          mLastInstr = memWord(mReqAddr);
          mLastPc    = mReqAddr;
          mPc        = mReqAddr + 16'd2;
        end
      end else if (ldI) begin
        mLive = 1'b0;
      end
      if (ldI) mPc = npI;
    end else if (mPres) begin
      if (ldI) begin
        mPres = 1'b0;
        mPc   = npI;
      end else if (!stI) begin
        mPres = 1'b0;
        if (mLastInstr[15:11] == 5'b00000) mHalt = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [15:0] randTarget();
    logic [15:0] t;
    case ($urandom_range(3, 0))
      0:       t = 16'hFFFC;
      1:       t = 16'hFFFE;
      default: t = 16'($urandom) & 16'hFFFE;
    endcase
    return t;
  endfunction

  initial begin
    bit reached;
    rst = 1'b1; pc_load = 1'b0; next_pc = '0; stall = 1'b0;
    mem_done = 1'b0; mem_rdata = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // reset state, then a clean stream at latency 1 with a stall on 0x1234
    stepCycle(1, 0, 16'h0, 0, 0);
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      reached = mPres && (mLastPc == 16'h0002);
      if (!reached) stepCycle(0, 0, 16'h0, 0, 0);
    end
    checkEq("reach1234", 16'(reached), 16'd1);
    for (int i = 0; i < 5; i++) stepCycle(0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 10; i++) stepCycle(0, 0, 16'h0, 0, 0);

    // redirect while waiting on a latency-3 read
    latLo = 3; latHi = 3;
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      reached = mOut && (respCnt >= 2);
      if (!reached) stepCycle(0, 0, 16'h0, 0, 0);
    end
    checkEq("reachWait", 16'(reached), 16'd1);
    stepCycle(0, 1, 16'h0100, 0, 0);
    for (int i = 0; i < 14; i++) stepCycle(0, 0, 16'h0, 0, 0);

    // redirect coincident with the memory response
    latLo = 2; latHi = 2;
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      reached = mOut && (respCnt == 1);
      if (!reached) stepCycle(0, 0, 16'h0, 0, 0);
    end
    checkEq("reachDone", 16'(reached), 16'd1);
    stepCycle(0, 1, 16'h0200, 0, 0);
    for (int i = 0; i < 12; i++) stepCycle(0, 0, 16'h0, 0, 0);

    // randomized traffic: variable latency, stalls, redirects incl. wrap
    latLo = 1; latHi = 4;
    for (int i = 0; i < 800; i++) begin
      bit ld;
      ld = ($urandom_range(99, 0) < 6);
      stepCycle(0, ld, randTarget(), ($urandom_range(99, 0) < 30), 0);
    end

    // HALT at 0x0006: presented, then parked and deaf to redirects
    haltEn = 1'b1;
    stepCycle(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      bit ld;
      ld = mHalt && ($urandom_range(99, 0) < 40);
      stepCycle(0, ld, randTarget(), ($urandom_range(99, 0) < 25), 0);
    end
    checkEq("haltedEnd", 16'(halted), 16'd1);
    haltEn = 1'b0;

    // reset mid-WAIT with a stray completion landing in the first REQ cycle
    latLo = 3; latHi = 3;
    stepCycle(1, 0, 16'h0, 0, 0);
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      reached = mOut && (respCnt >= 2);
      if (!reached) stepCycle(0, 0, 16'h0, 0, 0);
    end
    checkEq("reachWait2", 16'(reached), 16'd1);
    stepCycle(1, 0, 16'h0, 0, 0);
    stepCycle(0, 0, 16'h0, 0, 1);
    for (int i = 0; i < 20; i++) stepCycle(0, 0, 16'h0, 0, 0);

    // redirect to an odd address
    latLo = 1; latHi = 1;
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      reached = mPres;
      if (!reached) stepCycle(0, 0, 16'h0, 0, 0);
    end
    checkEq("reachOut", 16'(reached), 16'd1);
    stepCycle(0, 1, 16'h0003, 0, 0);
    for (int i = 0; i < 10; i++) stepCycle(0, 0, 16'h0, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkEq("misalignEnd", 16'(misalign), 16'd1);
`else
    checkEq("misalignEnd", 16'(misalign), 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sits at the opposite end of the execute stage's next-PC path: it owns the architectural PC register, accepts redirects (`next_pc`) computed by execute, and fetches 16-bit instructions from a multi-cycle instruction memory through a request/done handshake. It presents one instruction at a time to decode with a valid/stall handshake, squashes in-flight fetches on redirect, and parks after fetching HALT.

## Interface
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `next_pc`  in  16  redirect target from execute
- `pc_load`  in  1  redirect strobe; PC takes `next_pc` this edge
- `stall`  in  1  downstream not ready; hold presented instruction
- `mem_rd`  out  1  one-cycle read request to instruction memory
- `mem_addr`  out  16  read address, valid while `mem_rd`=1
- `mem_rdata`  in  16  read data, valid while `mem_done`=1
- `mem_done`  in  1  one-cycle completion pulse, at least 1 cycle after `mem_rd`
- `instr`  out  16  fetched instruction
- `instr_valid`  out  1  `instr`/`pc_out`/`pc_plus2` valid
- `pc_out`  out  16  address of `instr`
- `pc_plus2`  out  16  `pc_out`+2, wraps mod 2^16
- `halted`  out  1  HALT fetched and presented; fetch parked
- `misalign`  out  1  odd fetch address detected (see Configuration)

## Operation
- States: REQ, WAIT, OUT, HALTED.
- REQ: `mem_rd`=1, `mem_addr`=PC, clear squash; next state WAIT.
- WAIT: on `mem_done` with squash=0: latch `instr`<=`mem_rdata`, `pc_out`<=PC, `pc_plus2`<=PC+2, PC<=PC+2, go OUT. On `mem_done` with squash=1: discard data, clear squash, go REQ. No `mem_done`: stay.
- OUT: `instr_valid`=1. If `instr[15:11]`==5'b00000 (HALT): go HALTED once `stall`=0. Else if `stall`=0: go REQ. Else hold all outputs.
- HALTED: `instr_valid`=0, `halted`=1; `pc_load` and `stall` ignored; exit only via `rst`.
- Redirect (`pc_load`=1), priority over `stall` in every state except HALTED: PC<=`next_pc`.
  - REQ: the request at old PC is still issued this cycle; set squash, go WAIT.
  - WAIT: set squash; pending response dropped.
  - OUT: drop presented instruction (`instr_valid`=0 next cycle), go REQ.
- Only one request outstanding at any time; `mem_rd` never asserted in WAIT, OUT or HALTED.
- Arithmetic: all PC math unsigned 16-bit, carry discarded (0xFFFE+2 = 0x0000).

## Timing
- Reset values: PC=0x0000, state=REQ, `mem_rd`=0 during reset cycle, `instr`=0x0000, `instr_valid`=0, `pc_out`=0x0000, `pc_plus2`=0x0002, `halted`=0, `misalign`=0, squash=0.
- First `mem_rd` in first cycle after `rst` deasserts, `mem_addr`=0x0000.
- Fetch latency: `instr_valid` rises the cycle after `mem_done`; minimum request-to-valid 2 cycles.
- Throughput: one instruction per (mem latency + 2) cycles with `stall`=0.
- `pc_load` in the same cycle as `mem_done`: response squashed, REQ at `next_pc` next cycle.
- `rst` mid-WAIT: state to REQ; a later stray `mem_done` arriving in REQ is ignored.
- Outputs registered; `mem_rd`/`mem_addr` decoded from state and PC only.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: in REQ with PC[0]=1, no request issued; `misalign`<=1 (sticky until `rst`), go HALTED.
- Not defined: PC[0] passed to memory unchanged; `misalign` tied 0.

## Structure
- Shared package: state encoding (2-bit REQ/WAIT/OUT/HALTED), `OPC_HALT`=5'b00000, `PC_RESET`=16'h0000, `PC_STEP`=16'h0002.
- One sub-module: `pc_reg` (16-bit PC with sync reset, load, increment-by-2).

## Test plan
- Reset release, mem latency 1, `stall`=0: `mem_addr` 0x0000, 0x0002, 0x0004; `instr_valid` pulses with `pc_out` 0x0000, 0x0002, 0x0004; `pc_plus2` matches.
- `stall`=1 for 5 cycles in OUT with `instr`=0x1234: `instr`, `pc_out` stable, `instr_valid`=1, no `mem_rd`; next request the cycle after `stall` drops.
- `pc_load`, `next_pc`=0x0100 during WAIT (latency 3): old response discarded, never valid; next `mem_addr`=0x0100, `pc_out`=0x0100.
- `pc_load` coincident with `mem_done`: no valid for old data; next request at `next_pc`.
- `mem_rdata`=0x0000 at 0x0006: presented with `instr_valid`=1, then `halted`=1, no further `mem_rd`, `pc_load` ignored until `rst`.
- With `FETCH_ALIGN_CHECK_EN`: redirect to 0x0003 -> `misalign`=1, `halted`=1, no request to 0x0003; without it, `mem_addr`=0x0003.
